// File: rtl/matrix_add_sequencer.sv
// matrix_add_sequencer: loads A/B operands into the 5x5x8 adder bus and streams the sums back out.
// Optional load-idle timeout abort: define MATADD_SEQ_TIMEOUT_EN.

module matadd_seq_lane #(
  parameter int VEC_W = 8
) (
  input  logic             gclk,
  input  logic             grst_n,
  input  logic             clr,
  input  logic             wr_a,
  input  logic             wr_b,
  input  logic             ld_res,
  input  logic [VEC_W-1:0] din,
  input  logic [VEC_W-1:0] res_in,
  output logic [VEC_W-1:0] a_q,
  output logic [VEC_W-1:0] b_q,
  output logic [VEC_W-1:0] r_q
);
  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      a_q <= '0;
      b_q <= '0;
      r_q <= '0;
    end else begin
      if (clr) begin
        a_q <= '0;
        b_q <= '0;
      end else begin
        if (wr_a) a_q <= din;
        if (wr_b) b_q <= din;
      end
      if (ld_res) r_q <= res_in;
    end
  end
endmodule

module matrix_add_sequencer #(
  parameter int ELEM_W         = 8,
  parameter int MAX_DIM        = 5,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                start,
  input  logic [2:0]                          m_in,
  input  logic [2:0]                          n_in,
  input  logic [ELEM_W-1:0]                   in_data,
  input  logic                                in_valid,
  output logic                                in_ready,
  output logic [2:0]                          add_m,
  output logic [2:0]                          add_n,
  output logic [2*MAX_DIM*MAX_DIM*ELEM_W-1:0] add_operands,
  input  logic [MAX_DIM*MAX_DIM*ELEM_W-1:0]   add_result,
  input  logic                                add_valid,
  output logic [ELEM_W-1:0]                   out_data,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic                                busy,
  output logic                                done,
  output logic                                err
);
  localparam int NUM_LANES = MAX_DIM * MAX_DIM;
  localparam int SLOT_W    = $clog2(NUM_LANES + 1);
  localparam int DIM_W     = 3;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_A, S_LOAD_B, S_COMPUTE, S_OUTPUT, S_ERR
  } state_t;

  state_t                               state;
  logic [DIM_W-1:0]                     row, col, nrow, ncol;
  logic                                 col_last, row_last, dims_ok;
  logic                                 in_fire, out_fire, clr_ops, ld_res;
  logic [SLOT_W-1:0]                    slot_idx, nxt_idx;
  logic [NUM_LANES-1:0]                 wr_a, wr_b;
  logic [NUM_LANES-1:0][ELEM_W-1:0]     a_q, b_q, r_q;
  logic [ELEM_W-1:0]                    nxt_elem;

`ifdef MATADD_SEQ_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES);
  logic [TO_W-1:0] tcnt;
`else
  localparam int unused_timeout = TIMEOUT_CYCLES;
`endif

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;
  assign dims_ok  = (m_in != '0) && (m_in <= DIM_W'(MAX_DIM)) &&
                    (n_in != '0) && (n_in <= DIM_W'(MAX_DIM));
  assign clr_ops  = (state == S_IDLE) && start && dims_ok;
  assign ld_res   = (state == S_COMPUTE) && add_valid;

  // Row-major walk shared by the load and output phases.
  assign col_last = (col == add_n - 3'd1);
  assign row_last = (row == add_m - 3'd1);
  assign ncol     = col_last ? '0 : col + 3'd1;
  assign nrow     = col_last ? row + 3'd1 : row;
  assign slot_idx = SLOT_W'(row)  * SLOT_W'(MAX_DIM) + SLOT_W'(col);
  assign nxt_idx  = SLOT_W'(nrow) * SLOT_W'(MAX_DIM) + SLOT_W'(ncol);

  for (genvar s = 0; s < NUM_LANES; s++) begin : g_lane
    assign wr_a[s] = in_fire && (state == S_LOAD_A) && (slot_idx == SLOT_W'(s));
    assign wr_b[s] = in_fire && (state == S_LOAD_B) && (slot_idx == SLOT_W'(s));
    matadd_seq_lane #(.VEC_W(ELEM_W)) u_lane (
      .gclk   (clk),
      .grst_n (reset),
      .clr    (clr_ops),
      .wr_a   (wr_a[s]),
      .wr_b   (wr_b[s]),
      .ld_res (ld_res),
      .din    (in_data),
      .res_in (add_result[s*ELEM_W +: ELEM_W]),
      .a_q    (a_q[s]),
      .b_q    (b_q[s]),
      .r_q    (r_q[s])
    );
  end

  // Lane 0 sits at the LSB, so the packed arrays are already in bus order.
  assign add_operands = {b_q, a_q};

  always_comb begin
    nxt_elem = '0;
    for (int s = 0; s < NUM_LANES; s++)
      if (nxt_idx == SLOT_W'(s)) nxt_elem = r_q[s];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      add_m     <= '0;
      add_n     <= '0;
      row       <= '0;
      col       <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
`ifdef MATADD_SEQ_TIMEOUT_EN
      tcnt      <= '0;
`endif
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (dims_ok) begin
              add_m    <= m_in;
              add_n    <= n_in;
              row      <= '0;
              col      <= '0;
              in_ready <= 1'b1;
              state    <= S_LOAD_A;
`ifdef MATADD_SEQ_TIMEOUT_EN
              tcnt     <= '0;
`endif
            end else begin
              err   <= 1'b1;
              state <= S_ERR;
            end
          end
        end
        S_LOAD_A, S_LOAD_B: begin
          if (in_fire) begin
`ifdef MATADD_SEQ_TIMEOUT_EN
            tcnt <= '0;
`endif
            if (row_last && col_last) begin
              row <= '0;
              col <= '0;
              if (state == S_LOAD_A) begin
                state <= S_LOAD_B;
              end else begin
                in_ready <= 1'b0;
                state    <= S_COMPUTE;
              end
            end else begin
              row <= nrow;
              col <= ncol;
            end
          end
`ifdef MATADD_SEQ_TIMEOUT_EN
          else if (tcnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
            tcnt     <= '0;
            in_ready <= 1'b0;
            err      <= 1'b1;
            state    <= S_ERR;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
`endif
        end
        S_COMPUTE: begin
          if (add_valid) begin
            // Result reg loads on this same edge, so take slot 0 straight from the bus.
            out_valid <= 1'b1;
            out_data  <= add_result[ELEM_W-1:0];
            state     <= S_OUTPUT;
          end else begin
            err   <= 1'b1;
            state <= S_ERR;
          end
        end
        S_OUTPUT: begin
          if (out_fire) begin
            if (row_last && col_last) begin
              row       <= '0;
              col       <= '0;
              out_valid <= 1'b0;
              out_data  <= '0;
              busy      <= 1'b0;
              done      <= 1'b1;
              state     <= S_IDLE;
            end else begin
              row      <= nrow;
              col      <= ncol;
              out_data <= nxt_elem;
            end
          end
        end
        S_ERR: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_matrix_add_sequencer.sv
// Directed bench for matrix_add_sequencer with a behavioural lane-wise adder.
module tb_matrix_add_sequencer;
  logic         clk = 1'b0, reset = 1'b0, start = 1'b0;
  logic [2:0]   m_in = '0, n_in = '0;
  logic [7:0]   in_data = '0;
  logic         in_valid = 1'b0, in_ready;
  logic [2:0]   add_m, add_n;
  logic [399:0] add_operands, add_result;
  logic         add_valid = 1'b1;
  logic [7:0]   out_data;
  logic         out_valid, out_ready = 1'b0;
  logic         busy, done, err;

  matrix_add_sequencer #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset), .start(start), .m_in(m_in), .n_in(n_in),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .add_m(add_m), .add_n(add_n), .add_operands(add_operands),
    .add_result(add_result), .add_valid(add_valid),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  always_comb begin
    add_result = '0;
    for (int s = 0; s < 25; s++)
      add_result[s*8 +: 8] = add_operands[s*8 +: 8] + add_operands[200 + s*8 +: 8];
  end

  int cyc = 0, done_cnt = 0, err_cnt = 0;
  always @(posedge clk) begin
    cyc++;
    if (done) done_cnt++;
    if (err)  err_cnt++;
  end

  int n_cmp = 0, n_bad = 0;
  task automatic chk(input string tag, input logic [399:0] obs, input logic [399:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  logic [7:0] vec[$];
  logic [7:0] got[$];
  logic [7:0] stall_obs[$];

  task automatic idle(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic do_start(input logic [2:0] m, input logic [2:0] n);
    start = 1'b1; m_in = m; n_in = n;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic feed();
    foreach (vec[i]) begin
      int b = 0;
      while (!in_ready && b < 20) begin @(negedge clk); b++; end
      if (!in_ready) begin
        chk("feed_ready", in_ready, 1);
        break;
      end
      in_valid = 1'b1; in_data = vec[i];
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic collect(input int n, input int stall_idx, input int stall_len);
    int budget = 200;
    got.delete(); stall_obs.delete();
    while (got.size() < n && budget > 0) begin
      if (out_valid) begin
        if (got.size() == stall_idx && stall_obs.size() < stall_len) begin
          out_ready = 1'b0;
          stall_obs.push_back(out_data);
        end else begin
          out_ready = 1'b1;
          got.push_back(out_data);
        end
      end
      @(negedge clk);
      budget--;
    end
    out_ready = 1'b0;
    chk("collect_count", got.size(), n);
  endtask

  initial begin
    int c0, dc0, ec0;
    logic [399:0] exp_ops;
    logic [7:0] e;

    // reset state
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done_err", {done, err}, 0);
    chk("rst_ops", add_operands, 0);
    chk("rst_dims", {add_m, add_n}, 0);
    reset = 1'b1;
    idle(2);

    // 1: 2x3 job
    dc0 = done_cnt;
    do_start(3'd2, 3'd3);
    c0 = cyc;
    chk("t1_busy", busy, 1);
    chk("t1_in_ready", in_ready, 1);
    vec = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60};
    feed();
    exp_ops = '0;
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 3; c++) begin
        exp_ops[(r*5+c)*8 +: 8]       = 8'(r*3 + c + 1);
        exp_ops[200 + (r*5+c)*8 +: 8] = 8'(10*(r*3 + c + 1));
      end
    chk("t1_ops", add_operands, exp_ops);
    chk("t1_dims", {add_m, add_n}, {3'd2, 3'd3});
    chk("t1_in_ready_compute", in_ready, 0);
    collect(6, -1, 0);
    for (int i = 0; i < 6 && i < got.size(); i++) chk("t1_out", got[i], 8'(11*(i+1)));
    chk("t1_done", done, 1);
    chk("t1_latency", cyc - c0, 19);
    idle(1);
    chk("t1_done_clr", done, 0);
    chk("t1_busy_clr", busy, 0);
    idle(2);
    chk("t1_done_once", done_cnt - dc0, 1);

    // 2: bad dims
    do_start(3'd0, 3'd3);
    chk("t2a_err", err, 1);
    chk("t2a_in_ready", in_ready, 0);
    idle(1);
    chk("t2a_err_clr", err, 0);
    chk("t2a_busy", busy, 0);
    ec0 = err_cnt;
    do_start(3'd6, 3'd2);
    chk("t2b_err", err, 1);
    chk("t2b_in_ready", in_ready, 0);
    idle(1);
    chk("t2b_busy", {busy, err, in_ready}, 0);
    idle(1);
    chk("t2b_err_once", err_cnt - ec0, 1);

    // 3: 1x1 wrap
    do_start(3'd1, 3'd1);
    c0 = cyc;
    vec = '{8'hFF, 8'h02};
    feed();
    collect(1, -1, 0);
    if (got.size() > 0) chk("t3_out", got[0], 8'h01);
    chk("t3_done", done, 1);
    chk("t3_latency", cyc - c0, 4);
    idle(1);

    // 4: 2x2 with a 5-cycle stall on element 2
    do_start(3'd2, 3'd2);
    vec = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd100, 8'd100, 8'd100, 8'd100};
    feed();
    collect(4, 1, 5);
    chk("t4_stall_len", stall_obs.size(), 5);
    foreach (stall_obs[i]) chk("t4_stall_data", stall_obs[i], 8'd102);
    for (int i = 0; i < 4 && i < got.size(); i++) chk("t4_out", got[i], 8'(101 + i));
    chk("t4_done", done, 1);
    idle(1);

    // 5x5 full matrix, wrapping sums
    do_start(3'd5, 3'd5);
    c0 = cyc;
    vec.delete();
    for (int k = 0; k < 25; k++) vec.push_back(8'(k*11));
    for (int k = 0; k < 25; k++) vec.push_back(8'd200);
    feed();
    chk("t5x5_a_last", add_operands[199:192], 8'd8);
    chk("t5x5_b_last", add_operands[399:392], 8'd200);
    collect(25, -1, 0);
    for (int k = 0; k < 25 && k < got.size(); k++) begin
      e = 8'(k*11) + 8'd200;
      chk("t5x5_out", got[k], e);
    end
    chk("t5x5_latency", cyc - c0, 76);
    idle(1);

    // adder reports invalid
    add_valid = 1'b0;
    ec0 = err_cnt;
    do_start(3'd1, 3'd1);
    vec = '{8'd3, 8'd4};
    feed();
    @(negedge clk);
    chk("tinv_err", err, 1);
    chk("tinv_out_valid", out_valid, 0);
    add_valid = 1'b1;
    idle(2);
    chk("tinv_idle", {busy, err}, 0);
    chk("tinv_err_once", err_cnt - ec0, 1);

    // 5: reset after 3 B elements
    do_start(3'd2, 3'd2);
    vec = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7};
    feed();
    chk("t5_busy_before", busy, 1);
    dc0 = done_cnt; ec0 = err_cnt;
    reset = 1'b0;
    @(negedge clk);
    chk("t5_ops", add_operands, 0);
    chk("t5_flags", {busy, in_ready, out_valid, done, err}, 0);
    chk("t5_dims", {add_m, add_n}, 0);
    reset = 1'b1;
    idle(2);
    chk("t5_no_pulse", (done_cnt - dc0) + (err_cnt - ec0), 0);
    do_start(3'd1, 3'd1);
    vec = '{8'd7, 8'd9};
    feed();
    collect(1, -1, 0);
    if (got.size() > 0) chk("t5_out", got[0], 8'd16);
    chk("t5_done", done, 1);
    idle(1);

`ifdef MATADD_SEQ_TIMEOUT_EN
    // 6: load timeout after 16 idle cycles
    do_start(3'd1, 3'd1);
    idle(15);
    chk("t6_no_err_early", err, 0);
    idle(1);
    chk("t6_err", err, 1);
    chk("t6_in_ready", in_ready, 0);
    idle(1);
    chk("t6_idle", {busy, err}, 0);
`else
    // load waits indefinitely without the timeout
    ec0 = err_cnt;
    do_start(3'd1, 3'd1);
    idle(20);
    chk("t6_still_ready", in_ready, 1);
    chk("t6_no_err", err_cnt - ec0, 0);
    vec = '{8'd1, 8'd2};
    feed();
    collect(1, -1, 0);
    if (got.size() > 0) chk("t6_out", got[0], 8'd3);
    idle(1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
